// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, funct3 width codes,
// fault causes and the funct3 legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_ILLEGAL  = 2'b11;

    // Stores have no unsigned variants, so only B/H/W are accepted for them.
    function automatic logic f3_is_legal(input logic load, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (load) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated write data for
// stores, shift/extract/extend for load data.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN-1:0]   load_data
);

    logic [XLEN-1:0]    shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        mem_be    = '1;
        mem_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                mem_be    = 4'b0001 << offset;
                mem_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                mem_be    = 4'b0011 << offset;
                mem_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = mem_rdata >> {offset, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];

    // Signed size casts carry the sign bit into the upper lanes.
    always_comb begin
        case (funct3)
            F3_B:    load_data = XLEN'(byte_s);
            F3_H:    load_data = XLEN'(half_s);
            F3_BU:   load_data = XLEN'(shifted[7:0]);
            F3_HU:   load_data = XLEN'(shifted[15:0]);
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per start over a req/gnt/rvalid bus.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into faults.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   store_data,
    input  logic [2:0]        funct3,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   load_data,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_RESP = ST_RESP;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             is_load_q;
    logic             mem_we_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;

    logic             f3_legal;
    logic             misalign;
    logic             timeout;
    logic [1:0]       eff_off;
    logic [2:0]       al_f3;
    logic [1:0]       al_off;
    logic [XLEN/8-1:0] al_be;
    logic [XLEN-1:0]  al_wdata;
    logic [XLEN-1:0]  al_load;

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign mem_req = (state == S_REQ);
    assign mem_we  = mem_we_q & mem_req;
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Offset is always truncated to the access size; with the trap enabled
    // any access that would need truncating is rejected first.
    always_comb begin
        f3_legal = f3_is_legal(is_load, funct3);
        misalign = 1'b0;
        eff_off  = addr[1:0];
        case (funct3[1:0])
            2'b01: begin
                eff_off = {addr[1], 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
                misalign = addr[0];
`endif
            end
            2'b10: begin
                eff_off = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
                misalign = |addr[1:0];
`endif
            end
            default: ;
        endcase
    end

    // Store lanes are steered from the live inputs at start; load extraction
    // runs from the latched width/offset while the response arrives.
    assign al_f3  = (state == S_IDLE) ? funct3   : funct3_q;
    assign al_off = (state == S_IDLE) ? eff_off  : off_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (al_f3),
        .offset     (al_off),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .mem_be     (al_be),
        .mem_wdata  (al_wdata),
        .load_data  (al_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            is_load_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            fault       <= 1'b0;
            fault_cause <= FC_NONE;
            load_data   <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_load_q   <= is_load;
                        mem_we_q    <= is_store;
                        funct3_q    <= funct3;
                        off_q       <= eff_off;
                        fault       <= 1'b0;
                        fault_cause <= FC_NONE;
                        if (!is_load && !is_store) begin
                            state <= S_DONE;
                        end else if (!f3_legal) begin
                            state       <= S_DONE;
                            fault       <= 1'b1;
                            fault_cause <= FC_ILLEGAL;
                        end else if (misalign) begin
                            state       <= S_DONE;
                            fault       <= 1'b1;
                            fault_cause <= FC_MISALIGN;
                        end else begin
                            state     <= S_REQ;
                            cnt       <= '0;
                            mem_addr  <= {addr[XLEN-1:2], 2'b00};
                            mem_wdata <= al_wdata;
                            mem_be    <= is_store ? al_be : '1;
                        end
                    end
                end
                S_REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (timeout) begin
                        state       <= S_DONE;
                        fault       <= 1'b1;
                        fault_cause <= FC_TIMEOUT;
                    end else if (mem_gnt) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    cnt <= cnt + CNT_W'(1);
                    // A response on the timeout cycle still completes the access.
                    if (mem_rvalid) begin
                        state <= S_DONE;
                        if (is_load_q) begin
                            load_data <= al_load;
                        end
                    end else if (timeout) begin
                        state       <= S_DONE;
                        fault       <= 1'b1;
                        fault_cause <= FC_TIMEOUT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
